// File: rtl/rr_bus_mux.sv
// Round-robin shared-bus multiplexer: one owner at a time, registered data, turnaround gap between owners.
// Optional: define RR_BUS_MUX_BUS_KEEPER_EN to hold the last valid owner data on dout while idle.
module rr_bus_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int TURN_CYC = 1,
  parameter int MAX_HOLD = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       req,
  input  logic [CHANNELS*WIDTH-1:0] din,
  output logic [CHANNELS-1:0]       gnt,
  output logic [WIDTH-1:0]          dout,
  output logic                      dout_valid,
  output logic                      busy
);

  localparam int CW       = $clog2(CHANNELS);
  localparam int HW       = $clog2(MAX_HOLD + 2);
  localparam int HOLD_LIM = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

  typedef enum logic [1:0] {IDLE, OWN, TURN} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       last_q, last_d, pick;
  logic [HW-1:0]       hold_q, hold_d;
  logic [2:0]          turn_q, turn_d;
  logic [CHANNELS-1:0] gnt_q, gnt_d;
  logic [WIDTH-1:0]    dout_q, dout_d, own_data;
  logic                vld_q, vld_d, own_req, force_rel;

  // Scan downward so the channel nearest after last_q is the final (winning) assignment.
  always_comb begin
    int idx;
    pick = last_q;
    idx  = 0;
    for (int k = CHANNELS; k >= 1; k--) begin
      idx = int'(last_q) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (req[CW'(idx)]) pick = CW'(idx);
    end
  end

  always_comb begin
    own_data = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (last_q == CW'(i)) own_data = din[i*WIDTH +: WIDTH];
  end

  // While owning, last_q is the current owner.
  assign own_req   = req[last_q];
  assign force_rel = (MAX_HOLD != 0) && (hold_q == HW'(HOLD_LIM)) && (|(req & ~gnt_q));

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    gnt_d   = gnt_q;
    vld_d   = 1'b0;
`ifdef RR_BUS_MUX_BUS_KEEPER_EN
    dout_d  = dout_q;
`else
    dout_d  = '0;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d     = OWN;
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          last_d      = pick;
          hold_d      = '0;
        end
      end
      OWN: begin
        if (!own_req || force_rel) begin
          state_d = TURN;
          gnt_d   = '0;
          turn_d  = 3'(TURN_CYC - 1);
        end else begin
          vld_d  = 1'b1;
          dout_d = own_data;
          hold_d = (hold_q == {HW{1'b1}}) ? hold_q : hold_q + 1'b1;
        end
      end
      TURN: begin
        gnt_d = '0;
        if (turn_q == 3'd0) state_d = IDLE;
        else                turn_d  = turn_q - 3'd1;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= CW'(CHANNELS - 1);
      hold_q  <= '0;
      turn_q  <= '0;
      gnt_q   <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
      gnt_q   <= gnt_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
    end
  end

  assign gnt        = gnt_q;
  assign dout       = dout_q;
  assign dout_valid = vld_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_rr_bus_mux.sv
// Bench for rr_bus_mux: three configurations (default, MAX_HOLD=4, TURN_CYC=3) sharing one stimulus.
module tb_rr_bus_mux;
`ifdef RR_BUS_MUX_BUS_KEEPER_EN
  localparam bit KEEP = 1'b1;
`else
  localparam bit KEEP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] din = '0;
  logic [3:0]  gnt_o  [3];
  logic [7:0]  dout_o [3];
  logic        dv_o   [3];
  logic        busy_o [3];

  always #5 clk = ~clk;

  rr_bus_mux u_d0 (.clk(clk), .rst(rst), .req(req), .din(din),
    .gnt(gnt_o[0]), .dout(dout_o[0]), .dout_valid(dv_o[0]), .busy(busy_o[0]));
  rr_bus_mux #(.MAX_HOLD(4)) u_d1 (.clk(clk), .rst(rst), .req(req), .din(din),
    .gnt(gnt_o[1]), .dout(dout_o[1]), .dout_valid(dv_o[1]), .busy(busy_o[1]));
  rr_bus_mux #(.TURN_CYC(3)) u_d2 (.clk(clk), .rst(rst), .req(req), .din(din),
    .gnt(gnt_o[2]), .dout(dout_o[2]), .dout_valid(dv_o[2]), .busy(busy_o[2]));

  int nerr = 0, nchk = 0;

  // Reference model: owner index (-1 = none), edges left in the gap, edges held.
  int         turn_c [3] = '{1, 1, 3};
  int         mh     [3] = '{0, 4, 0};
  int         owner  [3], gap [3], held [3], last [3];
  logic [7:0] mdata  [3], mkeep [3];
  logic       mvalid [3];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 3; m++) begin
      owner[m] = -1; gap[m] = 0; held[m] = 0; last[m] = 3;
      mdata[m] = '0; mkeep[m] = '0; mvalid[m] = 1'b0;
    end
  endtask

  task automatic model_step(int m);
    logic [3:0] oth;
    mvalid[m] = 1'b0;
    if (owner[m] >= 0) begin
      oth = req & ~(4'b0001 << owner[m]);
      if (!req[owner[m]] || (mh[m] != 0 && held[m] == mh[m] - 1 && oth != 0)) begin
        owner[m] = -1;
        gap[m]   = turn_c[m];
      end else begin
        mdata[m]  = din[owner[m]*8 +: 8];
        mkeep[m]  = mdata[m];
        mvalid[m] = 1'b1;
        held[m]++;
      end
    end else if (gap[m] > 0) begin
      gap[m]--;
    end else if (req != 0) begin
      for (int k = 1; k <= 4; k++) begin
        if (owner[m] < 0 && req[(last[m] + k) % 4]) begin
          owner[m] = (last[m] + k) % 4;
          last[m]  = owner[m];
          held[m]  = 0;
        end
      end
    end
  endtask

  task automatic check_all(string tag);
    logic [3:0] eg;
    logic [7:0] ed;
    for (int m = 0; m < 3; m++) begin
      eg = (owner[m] >= 0) ? (4'b0001 << owner[m]) : 4'b0000;
      ed = mvalid[m] ? mdata[m] : (KEEP ? mkeep[m] : 8'h00);
      chk($sformatf("%s_m%0d_gnt", tag, m), 32'(gnt_o[m]), 32'(eg));
      chk($sformatf("%s_m%0d_dout", tag, m), 32'(dout_o[m]), 32'(ed));
      chk($sformatf("%s_m%0d_valid", tag, m), 32'(dv_o[m]), 32'(mvalid[m]));
      chk($sformatf("%s_m%0d_busy", tag, m), 32'(busy_o[m]), 32'(owner[m] >= 0 || gap[m] > 0));
    end
  endtask

  task automatic tick();
    for (int m = 0; m < 3; m++) model_step(m);
    @(posedge clk);
    #1;
    check_all("mdl");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic        pre_rst;
    logic [3:0]  req;
    logic [31:0] din;
    logic [3:0]  g;
    logic [7:0]  d;
    logic        v;
    logic        b;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(logic pr, logic [3:0] r, logic [31:0] di,
                              logic [3:0] g, logic [7:0] d, logic v, logic b);
    vec_t x;
    x.pre_rst = pr; x.req = r; x.din = di; x.g = g; x.d = d; x.v = v; x.b = b;
    vecs.push_back(x);
  endfunction

  int gcnt, vcnt, zc;
  bit got;

  initial begin
    logic [7:0] prevk, dat;
    logic [3:0] oh;
    // Single requester ch2, held for 3 data edges then dropped.
    add(1, 4'b0100, 32'h00A5_0000, 4'b0100, 8'h00, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 4'b0100, 32'h00A5_0000, 4'b0100, 8'hA5, 1, 1);
    add(0, 4'b0000, 32'h00A5_0000, 4'b0000, KEEP ? 8'hA5 : 8'h00, 0, 1);
    add(0, 4'b0000, 32'h00A5_0000, 4'b0000, KEEP ? 8'hA5 : 8'h00, 0, 0);
    add(0, 4'b0000, 32'h00A5_0000, 4'b0000, KEEP ? 8'hA5 : 8'h00, 0, 0);
    // Round robin: all request, each owner drops for one edge after 2 data edges.
    prevk = 8'h00;
    for (int o = 0; o < 4; o++) begin
      oh  = 4'b0001 << o;
      dat = 8'(8'h11 * (o + 1));
      add(o == 0, 4'b1111, 32'h4433_2211, oh, KEEP ? prevk : 8'h00, 0, 1);
      add(0, 4'b1111, 32'h4433_2211, oh, dat, 1, 1);
      add(0, 4'b1111, 32'h4433_2211, oh, dat, 1, 1);
      prevk = dat;
      add(0, 4'b1111 & ~oh, 32'h4433_2211, 4'b0000, KEEP ? prevk : 8'h00, 0, 1);
      add(0, 4'b1111, 32'h4433_2211, 4'b0000, KEEP ? prevk : 8'h00, 0, 0);
    end
    add(0, 4'b1111, 32'h4433_2211, 4'b0001, KEEP ? prevk : 8'h00, 0, 1);

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_all("rst");

    foreach (vecs[i]) begin
      if (vecs[i].pre_rst) do_reset();
      req = vecs[i].req;
      din = vecs[i].din;
      tick();
      chk($sformatf("tbl%0d_gnt", i), 32'(gnt_o[0]), 32'(vecs[i].g));
      chk($sformatf("tbl%0d_dout", i), 32'(dout_o[0]), 32'(vecs[i].d));
      chk($sformatf("tbl%0d_valid", i), 32'(dv_o[0]), 32'(vecs[i].v));
      chk($sformatf("tbl%0d_busy", i), 32'(busy_o[0]), 32'(vecs[i].b));
    end

    // Asynchronous reset in the middle of OWN, checked before any clock edge.
    do_reset();
    req = 4'b0001; din = 32'h0000_0077;
    tick(); tick();
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst_gnt", 32'(gnt_o[0]), 32'h0);
    chk("arst_dout", 32'(dout_o[0]), 32'h0);
    chk("arst_valid", 32'(dv_o[0]), 32'h0);
    chk("arst_busy", 32'(busy_o[0]), 32'h0);
    check_all("arst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    req = '0;

    // Forced release on the MAX_HOLD=4 instance: ch1 owns while ch3 waits.
    do_reset();
    req = 4'b1010; din = 32'hC300_5A00;
    gcnt = 0; vcnt = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (gnt_o[1] == 4'b0010) gcnt++;
      if (dv_o[1]) vcnt++;
      if (gnt_o[1] == 4'b1000) got = 1;
    end
    chk("force_grant_ch3", 32'(got), 32'h1);
    chk("force_own_edges", 32'(gcnt), 32'd4);
    chk("force_valid_edges", 32'(vcnt), 32'd3);

    // Turnaround width on the TURN_CYC=3 instance.
    do_reset();
    req = 4'b0001; din = 32'h0000_00AA;
    tick(); tick();
    req = 4'b0100;
    zc = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (gnt_o[2] == 4'b0100) got = 1;
      else if (gnt_o[2] == 4'b0000) zc++;
    end
    chk("turn3_grant_ch2", 32'(got), 32'h1);
    chk("turn3_gap_edges", 32'(zc), 32'd4);

    // Bus keeper behaviour after ch1 releases.
    do_reset();
    req = 4'b0010; din = 32'h0000_3C00;
    tick(); tick();
    chk("keep_data", 32'(dout_o[0]), 32'h3C);
    req = 4'b0000;
    tick();
    chk("keep_turn_dout", 32'(dout_o[0]), KEEP ? 32'h3C : 32'h0);
    chk("keep_turn_valid", 32'(dv_o[0]), 32'h0);
    tick();
    chk("keep_idle_dout", 32'(dout_o[0]), KEEP ? 32'h3C : 32'h0);

    // Randomized level-held requests against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      req = req ^ (4'($urandom) & 4'($urandom));
      din = $urandom;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
